// File: rtl/log_mul_div_sched.sv
// Controller and shared-access scheduler for the log-scale multiply/divide unit: streams the
// log2/exp2 LUT in from a ROM, then round-robins requesters onto the unit and routes results back.
module log_mul_div_sched #(
   parameter int unsigned FLOAT_LEN = 16,
   parameter int unsigned MANT_LEN  = 10,
   parameter int unsigned LUT_SIZE  = 128,
   parameter int unsigned PIPE_LAT  = 7,
   parameter int unsigned NUM_REQ   = 2,
   localparam int unsigned AW       = $clog2(LUT_SIZE)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           lut_load_start,
   output logic [AW-1:0]                  lut_src_addr,
   input  logic [MANT_LEN-1:0]            lut_src_log2,
   input  logic [FLOAT_LEN-1:0]           lut_src_exp2,
   output logic                           lut_ready,
   output logic                           busy,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*FLOAT_LEN-1:0]   req_a,
   input  logic [NUM_REQ*FLOAT_LEN-1:0]   req_b,
   input  logic [NUM_REQ-1:0]             req_op,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [FLOAT_LEN-1:0]           rsp_data,
   output logic [FLOAT_LEN-1:0]           u_a,
   output logic [FLOAT_LEN-1:0]           u_b,
   output logic                           u_mul_or_div,
   output logic                           u_lut_wr_en,
   output logic [FLOAT_LEN-1:0]           u_log2_lut_data,
   output logic [FLOAT_LEN-1:0]           u_exp2_lut_data,
   input  logic [FLOAT_LEN-1:0]           u_result
);

   localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [AW:0] CntEnd = (AW+1)'(LUT_SIZE);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StDrain} state_e;

   state_e                 state_q, state_d;
   logic [AW:0]            cnt_q, cnt_d;
   logic [IDW-1:0]         ptr_q, ptr_d;
   logic                   wr_en_q;
   logic                   addr_vld;
   logic [FLOAT_LEN-1:0]   u_a_q, u_b_q;
   logic                   u_op_q;
   logic [PIPE_LAT:0]      tag_vld_q;
   logic [IDW-1:0]         tag_id_q [PIPE_LAT+1];
   logic [NUM_REQ-1:0]     rsp_valid_q;
   logic [FLOAT_LEN-1:0]   rsp_data_q;

   logic                   gnt_found;
   logic [IDW-1:0]         gnt_id;
   logic                   handshake;
   logic [FLOAT_LEN-1:0]   sel_a, sel_b;
   logic                   sel_op;

   // Round-robin search: outer loop walks priority distance from the pointer.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      sel_a     = '0;
      sel_b     = '0;
      sel_op    = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && req_valid[i] && ((int'(ptr_q) + k) % NUM_REQ) == i) begin
               gnt_found = 1'b1;
               gnt_id    = IDW'(i);
               sel_a     = req_a[i*FLOAT_LEN +: FLOAT_LEN];
               sel_b     = req_b[i*FLOAT_LEN +: FLOAT_LEN];
               sel_op    = req_op[i];
            end
         end
      end
      handshake = (state_q == StRun) && gnt_found;
      req_ready = handshake ? (NUM_REQ'(1) << gnt_id) : '0;
      ptr_d     = handshake ? IDW'((int'(gnt_id) + 1) % NUM_REQ) : ptr_q;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         StIdle:  if (lut_load_start) state_d = StLoad;
         StLoad: begin
            if (cnt_q == CntEnd) begin
               state_d = StRun;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StRun:   if (lut_load_start) state_d = StDrain;
         StDrain: if (tag_vld_q == '0) state_d = StLoad;
         default: state_d = StIdle;
      endcase
   end

   assign addr_vld = (state_q == StLoad) && (cnt_q != CntEnd);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         ptr_q       <= '0;
         wr_en_q     <= 1'b0;
         u_a_q       <= '0;
         u_b_q       <= '0;
         u_op_q      <= 1'b0;
         tag_vld_q   <= '0;
         for (int k = 0; k <= PIPE_LAT; k++) tag_id_q[k] <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         wr_en_q   <= addr_vld;
         u_a_q     <= handshake ? sel_a : '0;
         u_b_q     <= handshake ? sel_b : '0;
         u_op_q    <= handshake & sel_op;
         tag_vld_q <= {tag_vld_q[PIPE_LAT-1:0], handshake};
         tag_id_q[0] <= gnt_id;
         for (int k = 1; k <= PIPE_LAT; k++) tag_id_q[k] <= tag_id_q[k-1];
         // Last tag stage lines up with the unit's result cycle.
         rsp_valid_q <= tag_vld_q[PIPE_LAT] ? (NUM_REQ'(1) << tag_id_q[PIPE_LAT]) : '0;
         if (tag_vld_q[PIPE_LAT]) rsp_data_q <= u_result;
      end
   end

   assign lut_src_addr    = cnt_q[AW-1:0];
   assign lut_ready       = (state_q == StRun);
   assign busy            = (state_q == StLoad) || (state_q == StDrain);
   assign u_lut_wr_en     = wr_en_q;
   assign u_log2_lut_data = wr_en_q ? {{(FLOAT_LEN-MANT_LEN){1'b0}}, lut_src_log2} : '0;
   assign u_exp2_lut_data = wr_en_q ? lut_src_exp2 : '0;
   assign u_a             = u_a_q;
   assign u_b             = u_b_q;
   assign u_mul_or_div    = u_op_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_data        = rsp_data_q;

endmodule

// File: doc/log_mul_div_sched.md
# log_mul_div_sched

Controller and shared-access scheduler for the log-scale multiply/divide unit (`log_scale_mul_div`):
- After reset it streams the 128-entry log2/exp2 LUT contents from an external synchronous ROM into the unit.
- It then arbitrates round-robin between NUM_REQ requesters for the single unit pipeline.
- It tracks each in-flight operation with a tag and routes every result back to its originating requester.
- It sits between the requester fabric and the unit. The unit has no stall input, so responses have no backpressure.

## Interface
- FLOAT_LEN, 16, operand/result width (fp16)
- MANT_LEN, 10, log2 LUT entry width
- LUT_SIZE, 128, LUT entries; address width AW = clog2(LUT_SIZE)
- PIPE_LAT, 7, unit latency in cycles, from operands applied to result valid
- NUM_REQ, 2, requester count (2..4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- lut_load_start  in  1  one-cycle pulse; requests a (re)load of the LUT
- lut_src_addr  out  AW  ROM address; ROM data is valid the cycle after the address
- lut_src_log2  in  MANT_LEN  ROM log2 entry
- lut_src_exp2  in  FLOAT_LEN  ROM exp2 entry
- lut_ready  out  1  LUT loaded; state is RUN
- busy  out  1  state is LOAD or DRAIN
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero
- req_a, req_b  in  NUM_REQ*FLOAT_LEN  operands; requester i occupies slice i
- req_op  in  NUM_REQ  0 = multiply, 1 = divide
- rsp_valid  out  NUM_REQ  one-hot result strobe
- rsp_data  out  FLOAT_LEN  result
- u_a, u_b  out  FLOAT_LEN  unit operands
- u_mul_or_div  out  1  unit operation select
- u_lut_wr_en  out  1  unit LUT write strobe
- u_log2_lut_data, u_exp2_lut_data  out  FLOAT_LEN  unit LUT write data; log2 is zero-extended from MANT_LEN

## Operation
- States:
  - IDLE: reset state; waits for lut_load_start.
  - LOAD: streams the LUT into the unit.
  - RUN: accepts and issues requests.
  - DRAIN: waits for in-flight operations to complete before a reload.
- Transitions:
  - IDLE → LOAD on lut_load_start.
  - LOAD → RUN after the final write.
  - RUN → DRAIN on lut_load_start.
  - DRAIN → LOAD when the tag pipe is empty.
  - lut_load_start is ignored in LOAD and DRAIN.
- LOAD behaviour:
  - lut_src_addr counts 0..LUT_SIZE-1, one address per cycle.
  - u_lut_wr_en is the address-valid flag delayed one cycle.
  - u_*_lut_data is a combinational pass-through of lut_src_*.
  - Exactly LUT_SIZE consecutive write cycles occur per load, in address order. The unit's write pointer wraps modulo LUT_SIZE, so alignment is preserved across reloads.
- Arbitration, in RUN only:
  - The requester nearest the round-robin pointer among those with req_valid set gets req_ready, combinationally.
  - After a grant to i, the pointer moves to i+1 mod NUM_REQ. The reset pointer is 0.
  - Outside RUN, req_ready = 0.
- Issue:
  - On a handshake (valid & ready) at an edge, u_a/u_b/u_mul_or_div are loaded from requester i's slice in the following cycle, called the issue cycle.
  - In non-issue cycles, u_a/u_b/u_mul_or_div are driven 0.
- Tag pipe:
  - PIPE_LAT+1 stages of {valid, id}. The issue cycle pushes {1, i}.
  - When the tag reaches the result stage, rsp_data is registered from the unit result and rsp_valid[id] is set for one cycle.
- Simultaneous events:
  - lut_load_start together with a handshake in RUN: the handshake completes and its operation is drained normally.
  - All responses issued before DRAIN are delivered before LOAD begins.
- Reset:
  - Clears state to IDLE and clears the pointer, counter and tag pipe. All in-flight results are discarded.
  - The system resets the unit in the same cycle.
  - After reset a new lut_load_start is required.

## Timing
- Reset values: lut_src_addr 0, lut_ready 0, busy 0, req_ready 0, rsp_valid 0, rsp_data 0, u_* 0.
- Load sequence, with lut_load_start sampled at edge E0:
  - Cycles 1..LUT_SIZE: addresses 0..LUT_SIZE-1.
  - Cycles 2..LUT_SIZE+1: u_lut_wr_en = 1.
  - Cycle LUT_SIZE+2 (130 with defaults): lut_ready = 1, busy = 0.
- Latency: handshake in cycle c → issue in cycle c+1 → unit result in cycle c+1+PIPE_LAT → rsp_valid in cycle c+2+PIPE_LAT (c+9 with defaults).
- Throughput: one operation per cycle. Responses appear in issue order.
- DRAIN exit: LOAD's first address appears in the cycle after the last rsp_valid. busy is high throughout DRAIN and LOAD.

## Test plan
- Reset, then lut_load_start → lut_src_addr steps 0..127 over 128 cycles; u_lut_wr_en high for exactly 128 cycles with ROM data lagging the address by one cycle; lut_ready rises in cycle 130.
- Requester 1 sends a=0x4000, b=0x4200, op=0 once → req_ready[1] in the same cycle; u_a=0x4000 in the next cycle; rsp_valid=0b10 and rsp_data=0x4600 9 cycles after the handshake.
- Both requesters hold valid for 8 cycles → grants alternate 0,1,0,1…; 8 responses on consecutive cycles with matching ids.
- lut_load_start in RUN with 3 operations in flight → req_ready=0 thereafter; all 3 responses delivered; the address-0 cycle immediately follows the last response; lut_ready is low until the reload completes.
- rst pulsed mid-LOAD (address 50) → all outputs 0 in the next cycle; state IDLE; req_valid held high still sees req_ready=0 until a new load completes.
- req_valid asserted before any load → req_ready stays 0; no u_a activity; no rsp_valid.
